// File: rtl/sram_port_arbiter.sv
// Purpose: round-robin arbiter sharing one single-port SRAM among IF, MEM, debug and DMA requesters.
// Latency: grant/select/cs/we combinational in the request cycle; rvalid registered one cycle after a read grant.
// Backpressure: stall_i blocks new grants and freezes pointer/lock state; already-launched reads still return.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   req_i/we_i/lock_i per-requester request, write flag and lock request (bit k = requester k)
//   stall_i           global freeze of arbitration
//   gnt_o, sel_o      one-hot grant and mux select of the winner (sel holds last winner when idle)
//   sram_cs_o/we_o    SRAM chip select / write enable
//   rvalid_o          one-hot read-data-valid, one cycle after a read grant
//   busy_o            a lock is currently held
module sram_port_arbiter #(
   parameter int MAX_LOCK = 4,
   parameter int CNT_W    = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] req_i,
   input  logic [3:0] we_i,
   input  logic [3:0] lock_i,
   input  logic       stall_i,
   output logic [3:0] gnt_o,
   output logic [1:0] sel_o,
   output logic       sram_cs_o,
   output logic       sram_we_o,
   output logic [3:0] rvalid_o,
   output logic       busy_o
);

   typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

   // A one-grant lock is meaningless, so locking is disabled entirely when MAX_LOCK is 1.
   localparam bit LOCK_EN = (MAX_LOCK > 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

   lock_state_t      state_q, state_d;
   logic [1:0]       ptr_q;
   logic [1:0]       sel_q;
   logic [1:0]       lock_own_q, lock_own_d;
   logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic [3:0]       rd_tag_q;

   logic             gnt_any;
   logic [1:0]       gnt_idx;
   logic [1:0]       cand;
   logic             take_lock;

   // Arbitration: lock owner first, otherwise rotate starting just after the last winner.
   // Reset gates the grant so every output reads 0 while rst_i is held.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = ptr_q;
      cand    = ptr_q;
      if (!rst_i && !stall_i) begin
         if (state_q == LOCKED && req_i[lock_own_q]) begin
            gnt_any = 1'b1;
            gnt_idx = lock_own_q;
         end else begin
            for (int i = 1; i <= 4; i++) begin
               cand = ptr_q + 2'(i);
               if (!gnt_any && req_i[cand]) begin
                  gnt_any = 1'b1;
                  gnt_idx = cand;
               end
            end
         end
      end
   end

   assign gnt_o     = gnt_any ? (4'b0001 << gnt_idx) : 4'b0000;
   // Hold the last select when idle so the address/data mux does not toggle.
   assign sel_o     = gnt_any ? gnt_idx : sel_q;
   assign sram_cs_o = gnt_any;
   assign sram_we_o = gnt_any & we_i[gnt_idx];
   assign rvalid_o  = rd_tag_q;
   assign busy_o    = (state_q == LOCKED);

   assign cnt_inc   = lock_cnt_q + CNT_W'(1);
   assign take_lock = LOCK_EN && gnt_any && lock_i[gnt_idx];

   // Lock FSM next-state. A grant is never issued under stall, but the freeze is
   // made explicit so a stalled cycle cannot be mistaken for the owner dropping req.
   always_comb begin
      state_d    = state_q;
      lock_own_d = lock_own_q;
      lock_cnt_d = lock_cnt_q;
      if (!stall_i) begin
         case (state_q)
            UNLOCKED: begin
               if (take_lock) begin
                  state_d    = LOCKED;
                  lock_own_d = gnt_idx;
                  lock_cnt_d = CNT_W'(1);
               end
            end
            LOCKED: begin
               if (gnt_any && gnt_idx == lock_own_q) begin
                  if (!lock_i[lock_own_q] || cnt_inc >= CNT_MAX) begin
                     state_d    = UNLOCKED;
                     lock_cnt_d = '0;
                  end else begin
                     lock_cnt_d = cnt_inc;
                  end
               end else begin
                  // Owner dropped its request: release, and let this cycle's
                  // winner take a fresh lock immediately if it asks for one.
                  state_d    = UNLOCKED;
                  lock_cnt_d = '0;
                  if (take_lock) begin
                     state_d    = LOCKED;
                     lock_own_d = gnt_idx;
                     lock_cnt_d = CNT_W'(1);
                  end
               end
            end
            default: state_d = UNLOCKED;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= UNLOCKED;
         lock_own_q <= 2'd0;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_own_q <= lock_own_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   // ptr_q resets to 3 so requester 0 is scanned first. The winner becomes the
   // pointer, which also puts a force-released lock owner at lowest priority.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q    <= 2'd3;
         sel_q    <= 2'd0;
         rd_tag_q <= 4'b0000;
      end else begin
         if (gnt_any) begin
            ptr_q <= gnt_idx;
            sel_q <= gnt_idx;
         end
         // Always updated: a read launched before a stall must still return.
         rd_tag_q <= gnt_o & ~we_i;
      end
   end

endmodule
